// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcode, state, op-class, dsrc, alu_op and MOV register-select encodings for cpu_ctrl
package cpu_ctrl_pkg;
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h3;
  localparam logic [3:0] OP_ALU = 4'h4;
  localparam logic [3:0] OP_LIM = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;
  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3} state_t;
  typedef enum logic [3:0] {C_NOP, C_LDA, C_STA, C_MOV, C_ALU, C_LIM, C_JMP, C_JZ, C_HLT} op_class_t;
  localparam logic [2:0] DSRC_MEM = 3'd0;
  localparam logic [2:0] DSRC_ALU = 3'd1;
  localparam logic [2:0] DSRC_A   = 3'd2;
  localparam logic [2:0] DSRC_B   = 3'd3;
  localparam logic [2:0] DSRC_M   = 3'd4;
  localparam logic [2:0] DSRC_P   = 3'd5;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_SHL = 3'd6;
  localparam logic [2:0] ALU_SHR = 3'd7;
  localparam logic [1:0] REG_A = 2'd0;
  localparam logic [1:0] REG_B = 2'd1;
  localparam logic [1:0] REG_M = 2'd2;
  localparam logic [1:0] REG_P = 2'd3;
endpackage

// File: rtl/cpu_decode.sv
// cpu_decode: combinational instruction decode (op class, MOV dst/src, ALU op, illegal opcode)
module cpu_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [7:0] ir,
  output op_class_t  cls,
  output logic [1:0] dst,
  output logic [1:0] src,
  output logic [2:0] alu_op,
  output logic       illegal
);
  always_comb begin
    case (ir[7:4])
      OP_LDA:  cls = C_LDA;
      OP_STA:  cls = C_STA;
      OP_MOV:  cls = C_MOV;
      OP_ALU:  cls = C_ALU;
      OP_LIM:  cls = C_LIM;
      OP_JMP:  cls = C_JMP;
      OP_JZ:   cls = C_JZ;
      OP_HLT:  cls = C_HLT;
      default: cls = C_NOP;
    endcase
  end
  assign dst     = ir[3:2];
  assign src     = ir[1:0];
  assign alu_op  = ir[2:0];
  assign illegal = ir[7] && (ir[7:4] != OP_HLT);
endmodule

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: tinycpu fetch/exec/mem sequencer and register-file strobes; CPU_CTRL_TRAP_EN halts on 0x8-0xE
module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  input  logic       a_zero,
  output logic       rA_we,
  output logic       rB_we,
  output logic       rM_we,
  output logic       rP_inc,
  output logic       rP_load,
  output logic [2:0] dsrc,
  output logic [2:0] alu_op,
  output logic [7:0] ir_out,
  output logic       halted,
  output logic       illegal
);
`ifdef CPU_CTRL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  state_t     state_q, state_d;
  logic [7:0] ir_q, ir_d;
  logic       ill_q, ill_d;
  op_class_t  cls;
  logic [1:0] dst, src;
  logic [2:0] dec_alu;
  logic       dec_ill;
  logic       req_c, we_c, sel_c, a_we_c, b_we_c, m_we_c, p_inc_c, p_load_c;
  cpu_decode u_dec (
    .ir      (ir_q),
    .cls     (cls),
    .dst     (dst),
    .src     (src),
    .alu_op  (dec_alu),
    .illegal (dec_ill)
  );
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    ill_d    = ill_q;
    req_c    = 1'b0;
    we_c     = 1'b0;
    sel_c    = 1'b0;
    a_we_c   = 1'b0;
    b_we_c   = 1'b0;
    m_we_c   = 1'b0;
    p_inc_c  = 1'b0;
    p_load_c = 1'b0;
    dsrc     = DSRC_MEM;
    alu_op   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          p_inc_c = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (cls)
          C_LDA, C_STA, C_LIM: state_d = S_MEM;
          C_MOV: begin
            a_we_c = dst == REG_A;
            b_we_c = dst == REG_B;
            m_we_c = dst == REG_M;
            dsrc   = (dst == REG_P) ? DSRC_MEM : DSRC_A + {1'b0, src};
          end
          C_ALU: begin
            a_we_c = 1'b1;
            dsrc   = DSRC_ALU;
            alu_op = dec_alu;
          end
          C_JMP:   p_load_c = 1'b1;
          C_JZ:    p_load_c = a_zero;
          C_HLT:   state_d = S_HALT;
          default: begin
            if (TRAP && dec_ill) begin
              state_d = S_HALT;
              ill_d   = 1'b1;
            end
          end
        endcase
      end
      S_MEM: begin
        req_c = 1'b1;
        sel_c = cls != C_LIM;
        we_c  = cls == C_STA;
        if (mem_ack) begin
          state_d = S_FETCH;
          a_we_c  = cls == C_LDA;
          m_we_c  = cls == C_LIM;
          p_inc_c = cls == C_LIM;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      ir_q    <= 8'h00;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ill_q   <= ill_d;
    end
  end
  assign mem_req      = rst & req_c;
  assign mem_we       = rst & we_c;
  assign mem_addr_sel = sel_c;
  assign rA_we        = rst & a_we_c;
  assign rB_we        = rst & b_we_c;
  assign rM_we        = rst & m_we_c;
  assign rP_inc       = rst & p_inc_c;
  assign rP_load      = rst & p_load_c;
  assign ir_out       = ir_q;
  assign halted       = state_q == S_HALT;
  assign illegal      = ill_q;
endmodule

// File: tb/tb_cpu_ctrl.sv
// tb_cpu_ctrl: directed self-checking bench for cpu_ctrl; honours CPU_CTRL_TRAP_EN for the illegal-opcode step
module tb_cpu_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic       a_zero = 1'b0;
  logic       mem_req, mem_we, mem_addr_sel;
  logic       rA_we, rB_we, rM_we, rP_inc, rP_load;
  logic [2:0] dsrc, alu_op;
  logic [7:0] ir_out;
  logic       halted, illegal;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sv;
  cpu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .a_zero       (a_zero),
    .rA_we        (rA_we),
    .rB_we        (rB_we),
    .rM_we        (rM_we),
    .rP_inc       (rP_inc),
    .rP_load      (rP_load),
    .dsrc         (dsrc),
    .alu_op       (alu_op),
    .ir_out       (ir_out),
    .halted       (halted),
    .illegal      (illegal)
  );
  always #5 clk = ~clk;
  assign sv = {mem_req, mem_we, mem_addr_sel, rA_we, rB_we, rM_we, rP_inc, rP_load};
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic ack, input logic [7:0] rd);
    mem_ack   = ack;
    mem_rdata = rd;
    #1;
  endtask
  initial begin
    #3;
    chk("rst_strobes", sv, 8'h00);
    chk("rst_ir", ir_out, 8'h00);
    chk("rst_halted", {7'b0, halted}, 8'h00);
    chk("rst_illegal", {7'b0, illegal}, 8'h00);
    tick();
    rst = 1'b1;
    drive(1'b1, 8'h00);
    chk("fetch0", sv, 8'h82);
    tick();
    drive(1'b0, 8'h00);
    chk("nop_ir", ir_out, 8'h00);
    chk("nop_exec", sv, 8'h00);
    tick();
    chk("fetch1_wait", sv, 8'h80);
    tick();
    drive(1'b1, 8'h50);
    chk("fetch_lim", sv, 8'h82);
    tick();
    drive(1'b1, 8'h3C);
    chk("lim_exec_ack_ignored", sv, 8'h00);
    chk("lim_ir", ir_out, 8'h50);
    tick();
    chk("lim_mem", sv, 8'h86);
    chk("lim_dsrc", {5'b0, dsrc}, 8'h00);
    tick();
    drive(1'b1, 8'h41);
    chk("fetch_sub", sv, 8'h82);
    tick();
    drive(1'b0, 8'h00);
    chk("sub_exec", sv, 8'h10);
    chk("sub_dsrc", {5'b0, dsrc}, 8'h01);
    chk("sub_alu", {5'b0, alu_op}, 8'h01);
    tick();
    drive(1'b1, 8'h36);
    tick();
    drive(1'b0, 8'h00);
    chk("mov_exec", sv, 8'h08);
    chk("mov_dsrc", {5'b0, dsrc}, 8'h04);
    chk("mov_alu", {5'b0, alu_op}, 8'h00);
    tick();
    drive(1'b1, 8'h70);
    tick();
    drive(1'b0, 8'h00);
    a_zero = 1'b1;
    #1;
    chk("jz_taken", sv, 8'h01);
    tick();
    drive(1'b1, 8'h70);
    tick();
    drive(1'b0, 8'h00);
    a_zero = 1'b0;
    #1;
    chk("jz_not_taken", sv, 8'h00);
    tick();
    drive(1'b1, 8'h20);
    tick();
    drive(1'b0, 8'h00);
    chk("sta_exec", sv, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sta_wait", sv, 8'hE0);
      tick();
    end
    drive(1'b1, 8'h00);
    chk("sta_ack", sv, 8'hE0);
    tick();
    drive(1'b1, 8'h20);
    chk("fetch_sta2", sv, 8'h82);
    tick();
    drive(1'b0, 8'h00);
    tick();
    chk("sta2_wait1", sv, 8'hE0);
    tick();
    chk("sta2_wait2", sv, 8'hE0);
    rst = 1'b0;
    #1;
    chk("rst_mid_mem", sv, 8'h00);
    drive(1'b1, 8'h00);
    chk("rst_ack_ignored", sv, 8'h00);
    tick();
    rst = 1'b1;
    drive(1'b1, 8'hF0);
    chk("fetch_after_rst", sv, 8'h82);
    tick();
    drive(1'b0, 8'h00);
    chk("hlt_exec", sv, 8'h00);
    chk("hlt_not_yet", {7'b0, halted}, 8'h00);
    tick();
    drive(1'b1, 8'h00);
    chk("halted", {7'b0, halted}, 8'h01);
    for (int i = 0; i < 20; i++) begin
      chk("halt_quiet", sv, 8'h00);
      tick();
    end
    rst = 1'b0;
    tick();
    chk("halt_cleared", {7'b0, halted}, 8'h00);
    rst = 1'b1;
    drive(1'b1, 8'h80);
    chk("fetch_ill", sv, 8'h82);
    tick();
    drive(1'b0, 8'h00);
    chk("ill_exec", sv, 8'h00);
    tick();
`ifdef CPU_CTRL_TRAP_EN
    chk("ill_halted", {7'b0, halted}, 8'h01);
    chk("ill_flag", {7'b0, illegal}, 8'h01);
    chk("ill_quiet", sv, 8'h00);
`else
    chk("ill_halted", {7'b0, halted}, 8'h00);
    chk("ill_flag", {7'b0, illegal}, 8'h00);
    chk("ill_next_fetch", sv, 8'h80);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
